piece_mover: RTL and testbench



---
 rtl/tetris_pkg.sv | 21 ++
 rtl/frame_tick_gen.sv | 36 +++
 rtl/piece_mover.sv | 218 +++++++++++++++++++++
 tb/tb_piece_mover.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared definitions for the Tetris play-field blocks.
//   KEY_*         : keyboard scan codes the movers react to (KEY_NONE = no key)
//   mover_state_t : piece_mover state encoding (DROP is only reachable when
//                   the design is built with HARD_DROP_EN defined)
package tetris_pkg;

    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam logic [7:0] KEY_A    = 8'h04;
    localparam logic [7:0] KEY_D    = 8'h07;
    localparam logic [7:0] KEY_S    = 8'h16;
    localparam logic [7:0] KEY_W    = 8'h1A;

    typedef enum logic [2:0] {
        IDLE,
        FALLING,
        HGRAV,
        LOCK,
        DROP
    } mover_state_t;

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: turns the asynchronous ~60 Hz frame strobe into a one-cycle
// tick in the clk domain. Two-flop synchroniser, rising-edge detect, and a
// registered output, so tick is high during the 3rd cycle after the edge.
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   frame_clk in  asynchronous frame strobe (level)
//   tick      out one-cycle pulse per frame_clk rising edge
module frame_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_clk,
    output logic tick
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic tick_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            tick_reg  <= 1'b0;
        end else begin
            sync1_reg <= frame_clk;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            tick_reg  <= sync2_reg & ~prev_reg;
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/piece_mover.sv
// piece_mover: grid-based falling 1-cell piece for the Tetris play field.
// Gravity on frame ticks, A/D moves with auto-repeat, S soft drop, wall and
// stack collision, lock-down pulse, and pixel flags for the colour mapper.
// Optional feature macro: HARD_DROP_EN (W hard-drops the piece via DROP).
//   Clk, Reset_n               clock, asynchronous active-low reset
//   frame_clk                  asynchronous frame strobe
//   keycode                    current key (A/D/S/W, anything else = none)
//   DrawX, DrawY               current pixel
//   spawn                      one-cycle request to place a new piece (IDLE only)
//   occ_left/right/below       board occupancy next to (piece_col, piece_row)
//   piece_col, piece_row       current piece cell
//   active                     piece is falling
//   locked                     one-cycle pulse, position holds the lock cell
//   is_piece, play_area        pixel flags
module piece_mover
    import tetris_pkg::*;
#(
    parameter int GRID_COLS      = 10,
    parameter int GRID_ROWS      = 20,
    parameter int CELL_PX        = 20,
    parameter int PLAY_X0        = 220,
    parameter int PLAY_Y0        = 40,
    parameter int GRAVITY_FRAMES = 16,
    parameter int REPEAT_DELAY   = 10,
    parameter int REPEAT_RATE    = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       spawn,
    input  logic       occ_left,
    input  logic       occ_right,
    input  logic       occ_below,
    output logic [4:0] piece_col,
    output logic [4:0] piece_row,
    output logic       active,
    output logic       locked,
    output logic       is_piece,
    output logic       play_area
);

    localparam logic [4:0] COL_LAST  = 5'(GRID_COLS - 1);
    localparam logic [4:0] ROW_LAST  = 5'(GRID_ROWS - 1);
    localparam logic [4:0] COL_SPAWN = 5'(GRID_COLS / 2 - 1);

    localparam int GW = $clog2(GRAVITY_FRAMES);
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [GW-1:0] G_LAST  = GW'(GRAVITY_FRAMES - 1);
    localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
    // Held count that triggers the next repeat; the counter folds back to
    // R_DELAY there, so it never grows past this value.
    localparam logic [RW-1:0] R_WRAP  = RW'(REPEAT_DELAY + REPEAT_RATE);

    localparam logic [9:0] PX_X0   = 10'(PLAY_X0);
    localparam logic [9:0] PX_Y0   = 10'(PLAY_Y0);
    localparam logic [9:0] PX_X1   = 10'(PLAY_X0 + GRID_COLS * CELL_PX - 1);
    localparam logic [9:0] PX_Y1   = 10'(PLAY_Y0 + GRID_ROWS * CELL_PX - 1);
    localparam logic [9:0] PX_CELL = 10'(CELL_PX);
    localparam logic [9:0] PX_SPAN = 10'(CELL_PX - 1);

    mover_state_t  state_reg, state_next;
    logic [4:0]    col_reg, col_next;
    logic [4:0]    row_reg, row_next;
    logic [GW-1:0] gcount_reg, gcount_next;
    logic [RW-1:0] rcount_reg, rcount_next;
    logic [7:0]    key_reg, key_next;   // key seen at the previous tick

    logic          tick;
    logic [7:0]    key_now;
    logic          fresh;
    logic          h_move;
    logic          g_due;
    logic [RW-1:0] r_inc;

    frame_tick_gen u_tick (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    // Unrecognised codes collapse to KEY_NONE so that switching between two
    // meaningless keys never counts as a fresh press.
    always_comb begin
        key_now = KEY_NONE;
        case (keycode)
            KEY_A, KEY_D, KEY_S: key_now = keycode;
`ifdef HARD_DROP_EN
            KEY_W:               key_now = keycode;
`endif
            default:             key_now = KEY_NONE;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        col_next    = col_reg;
        row_next    = row_reg;
        gcount_next = gcount_reg;
        rcount_next = rcount_reg;
        key_next    = key_reg;
        fresh       = 1'b0;
        h_move      = 1'b0;
        g_due       = 1'b0;
        r_inc       = rcount_reg + 1'b1;

        case (state_reg)
            IDLE: begin
                if (spawn) begin
                    state_next  = FALLING;
                    col_next    = COL_SPAWN;
                    row_next    = 5'd0;
                    gcount_next = '0;
                    rcount_next = '0;
                    key_next    = KEY_NONE;
                end
            end

            FALLING: begin
                if (tick) begin
                    // Horizontal phase; gravity follows in HGRAV so occ_below
                    // is looked up at the updated column.
                    fresh       = (key_now != key_reg);
                    h_move      = fresh || (r_inc == R_DELAY) || (r_inc == R_WRAP);
                    rcount_next = fresh ? RW'(1) : ((r_inc == R_WRAP) ? R_DELAY : r_inc);
                    key_next    = key_now;
                    state_next  = HGRAV;
                    if (h_move && key_now == KEY_A && col_reg != 5'd0 && !occ_left)
                        col_next = col_reg - 5'd1;
                    if (h_move && key_now == KEY_D && col_reg != COL_LAST && !occ_right)
                        col_next = col_reg + 5'd1;
`ifdef HARD_DROP_EN
                    if (fresh && key_now == KEY_W)
                        state_next = DROP;
`endif
                end
            end

            HGRAV: begin
                g_due       = (key_reg == KEY_S) || (gcount_reg == G_LAST);
                gcount_next = g_due ? '0 : gcount_reg + 1'b1;
                state_next  = FALLING;
                if (g_due) begin
                    if (row_reg == ROW_LAST || occ_below)
                        state_next = LOCK;
                    else
                        row_next = row_reg + 5'd1;
                end
            end

            LOCK: begin
                state_next = IDLE;
            end

`ifdef HARD_DROP_EN
            DROP: begin
                // One row per clock; frame ticks are ignored until lock.
                if (row_reg != ROW_LAST && !occ_below)
                    row_next = row_reg + 5'd1;
                else
                    state_next = LOCK;
            end
`endif

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg  <= IDLE;
            col_reg    <= 5'd0;
            row_reg    <= 5'd0;
            gcount_reg <= '0;
            rcount_reg <= '0;
            key_reg    <= KEY_NONE;
        end else begin
            state_reg  <= state_next;
            col_reg    <= col_next;
            row_reg    <= row_next;
            gcount_reg <= gcount_next;
            rcount_reg <= rcount_next;
            key_reg    <= key_next;
        end
    end

    assign piece_col = col_reg;
    assign piece_row = row_reg;
    assign locked    = (state_reg == LOCK);

    // The piece stays visible while hard-dropping.
    always_comb begin
        active = (state_reg == FALLING) || (state_reg == HGRAV);
`ifdef HARD_DROP_EN
        if (state_reg == DROP)
            active = 1'b1;
`endif
    end

    // Pixel flags: bounds are built by addition only, all in 10-bit unsigned.
    logic [9:0] cell_x0, cell_y0;
    logic       in_cell, in_play;

    assign cell_x0  = PX_X0 + 10'(col_reg) * PX_CELL;
    assign cell_y0  = PX_Y0 + 10'(row_reg) * PX_CELL;
    assign in_cell  = (DrawX >= cell_x0) && (DrawX <= cell_x0 + PX_SPAN) &&
                      (DrawY >= cell_y0) && (DrawY <= cell_y0 + PX_SPAN);
    assign in_play  = (DrawX >= PX_X0) && (DrawX <= PX_X1) &&
                      (DrawY >= PX_Y0) && (DrawY <= PX_Y1);
    assign is_piece  = active && in_cell;
    assign play_area = in_play && !is_piece;

endmodule

// File: tb/tb_piece_mover.sv
module tb_piece_mover;
    import tetris_pkg::*;

    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int CPX    = 20;
    localparam int X0     = 220;
    localparam int Y0     = 40;
    localparam int GF     = 16;
    localparam int RD     = 10;
    localparam int RR     = 3;
    localparam int NTICKS = 1200;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic       spawn = 1'b0;
    logic       occ_left, occ_right, occ_below;
    logic [4:0] piece_col, piece_row;
    logic       active, locked, is_piece, play_area;

    piece_mover #(
        .GRID_COLS(COLS), .GRID_ROWS(ROWS), .CELL_PX(CPX),
        .PLAY_X0(X0), .PLAY_Y0(Y0), .GRAVITY_FRAMES(GF),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
        .DrawX(DrawX), .DrawY(DrawY), .spawn(spawn),
        .occ_left(occ_left), .occ_right(occ_right), .occ_below(occ_below),
        .piece_col(piece_col), .piece_row(piece_row), .active(active),
        .locked(locked), .is_piece(is_piece), .play_area(play_area)
    );

    always #10 Clk = ~Clk;

    // Board RAM stand-in: occupancy around the DUT's current cell.
    bit board [ROWS][COLS];

    always_comb begin
        occ_left  = 1'b0;
        occ_right = 1'b0;
        occ_below = 1'b0;
        if (int'(piece_row) < ROWS && int'(piece_col) < COLS) begin
            if (int'(piece_col) > 0)
                occ_left = board[int'(piece_row)][int'(piece_col) - 1];
            if (int'(piece_col) < COLS - 1)
                occ_right = board[int'(piece_row)][int'(piece_col) + 1];
            if (int'(piece_row) < ROWS - 1)
                occ_below = board[int'(piece_row) + 1][int'(piece_col)];
        end
    end

    typedef struct {
        int col;
        int row;
    } pos_t;

    pos_t pos_q[$];
    pos_t lock_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model state.
    int         m_col = 0;
    int         m_row = 0;
    bit         m_active = 1'b0;
    int         m_g = 0;
    int         m_held = 0;
    logic [7:0] m_prev_key = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit occ(input int r, input int c);
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
        return board[r][c];
    endfunction

    function automatic logic [7:0] norm(input logic [7:0] k);
        if (k == KEY_A || k == KEY_D || k == KEY_S) return k;
`ifdef HARD_DROP_EN
        if (k == KEY_W) return k;
`endif
        return KEY_NONE;
    endfunction

    task automatic set_pos(input int c, input int r);
        if (c != m_col || r != m_row) pos_q.push_back('{c, r});
        m_col = c;
        m_row = r;
    endtask

    task automatic do_lock();
        lock_q.push_back('{m_col, m_row});
        m_active = 1'b0;
    endtask

    task automatic model_spawn();
        m_active   = 1'b1;
        set_pos(COLS / 2 - 1, 0);
        m_g        = 0;
        m_held     = 0;
        m_prev_key = KEY_NONE;
    endtask

    // One frame of the game rules: horizontal, then gravity.
    task automatic model_tick(input logic [7:0] raw);
        logic [7:0] k;
        bit fresh, mv, due;
        if (!m_active) return;
        k          = norm(raw);
        fresh      = (k != m_prev_key);
        m_held     = fresh ? 1 : m_held + 1;
        m_prev_key = k;
        mv = fresh || (m_held == RD) || (m_held > RD && (m_held - RD) % RR == 0);
`ifdef HARD_DROP_EN
        if (fresh && k == KEY_W) begin
            while (m_row < ROWS - 1 && !occ(m_row + 1, m_col))
                set_pos(m_col, m_row + 1);
            do_lock();
            return;
        end
`endif
        if (k == KEY_A && mv && m_col > 0 && !occ(m_row, m_col - 1))
            set_pos(m_col - 1, m_row);
        if (k == KEY_D && mv && m_col < COLS - 1 && !occ(m_row, m_col + 1))
            set_pos(m_col + 1, m_row);
        m_g++;
        due = 1'b0;
        if (k == KEY_S || m_g == GF) begin
            due = 1'b1;
            m_g = 0;
        end
        if (due) begin
            if (m_row == ROWS - 1 || occ(m_row + 1, m_col)) do_lock();
            else set_pos(m_col, m_row + 1);
        end
    endtask

    // Monitor: pops expectations whenever the DUT shows a lock or a move.
    logic [4:0] last_col = 5'd0;
    logic [4:0] last_row = 5'd0;
    pos_t       mon_p;

    always @(negedge Clk) begin
        if (mon_en) begin
            if (locked) begin
                if (lock_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lock_event: unexpected locked pulse at col %0d row %0d",
                             piece_col, piece_row);
                end else begin
                    mon_p = lock_q.pop_front();
                    chk("lock_col", int'(piece_col), mon_p.col);
                    chk("lock_row", int'(piece_row), mon_p.row);
                end
            end
            if (piece_col != last_col || piece_row != last_row) begin
                if (pos_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL move_event: unexpected move to col %0d row %0d",
                             piece_col, piece_row);
                end else begin
                    mon_p = pos_q.pop_front();
                    chk("move_col", int'(piece_col), mon_p.col);
                    chk("move_row", int'(piece_row), mon_p.row);
                end
                last_col = piece_col;
                last_row = piece_row;
            end
        end
    end

    task automatic new_board(input int pct);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                board[r][c] = (r > 1) && (int'($urandom_range(0, 99)) < pct);
    endtask

    task automatic pulse_spawn();
        @(negedge Clk);
        spawn = 1'b1;
        @(negedge Clk);
        spawn = 1'b0;
    endtask

    task automatic do_tick();
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (28) @(negedge Clk);
    endtask

    task automatic pixel_check();
        int x, y;
        bit ep, ea;
        for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                x = X0 + m_col * CPX + int'($urandom_range(0, CPX + 1)) - 1;
                y = Y0 + m_row * CPX + int'($urandom_range(0, CPX + 1)) - 1;
            end else begin
                x = int'($urandom_range(0, 639));
                y = int'($urandom_range(0, 479));
            end
            DrawX = 10'(x);
            DrawY = 10'(y);
            #1;
            ep = m_active && x >= X0 + m_col * CPX && x < X0 + (m_col + 1) * CPX &&
                 y >= Y0 + m_row * CPX && y < Y0 + (m_row + 1) * CPX;
            ea = !ep && x >= X0 && x < X0 + COLS * CPX && y >= Y0 && y < Y0 + ROWS * CPX;
            chk("is_piece", int'(is_piece), int'(ep));
            chk("play_area", int'(play_area), int'(ea));
        end
    endtask

    function automatic logic [7:0] pick_key();
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 25) return KEY_NONE;
        if (r < 45) return KEY_A;
        if (r < 65) return KEY_D;
        if (r < 80) return KEY_S;
        if (r < 90) return KEY_W;
        return 8'h2C;
    endfunction

    initial begin
        logic [7:0] cur_key;
        int         hold_left;
        cur_key   = KEY_NONE;
        hold_left = 0;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("reset_col", int'(piece_col), 0);
        chk("reset_row", int'(piece_row), 0);
        chk("reset_active", int'(active), 0);
        chk("reset_locked", int'(locked), 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        mon_en = 1'b1;

        // Randomised play; first piece holds D on an empty board to hit the wall.
        for (int n = 0; n < NTICKS; n++) begin
            if (!m_active) begin
                new_board(n == 0 ? 0 : 8);
                model_spawn();
                pulse_spawn();
            end else if ($urandom_range(0, 19) == 0) begin
                pulse_spawn();
            end
            if (hold_left == 0) begin
                cur_key   = pick_key();
                hold_left = int'($urandom_range(1, 24));
            end
            if (n < 30) cur_key = KEY_D;
            hold_left--;
            chk("active", int'(active), int'(m_active));
            pixel_check();
            keycode = cur_key;
            model_tick(cur_key);
            do_tick();
        end

        // Soft-drop whatever is falling to the floor.
        for (int k = 0; k < 25 && m_active; k++) begin
            keycode = KEY_S;
            model_tick(KEY_S);
            do_tick();
        end
        chk("pending_moves", pos_q.size(), 0);
        chk("pending_locks", lock_q.size(), 0);

        // Reset in the middle of a fall.
        new_board(0);
        model_spawn();
        pulse_spawn();
        for (int k = 0; k < 12; k++) begin
            keycode = KEY_S;
            model_tick(KEY_S);
            do_tick();
        end
        chk("prefall_row", int'(piece_row), m_row);
        chk("prefall_active", int'(active), int'(m_active));
        mon_en = 1'b0;
        #5;
        Reset_n = 1'b0;
        #1;
        chk("async_col", int'(piece_col), 0);
        chk("async_row", int'(piece_row), 0);
        chk("async_active", int'(active), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("no_lock_in_reset", int'(locked), 0);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("idle_after_reset", int'(active), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
